// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the registered sequential ALU.
// Holds the 4-bit opcode map that the decode stage already emits and the
// three-state handshake FSM encoding used by seq_alu.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_ADDI  = 4'h1,
    OP_SUB   = 4'h2,
    OP_SHL   = 4'h3,
    OP_MUL   = 4'h4,
    OP_BEQ0  = 4'h5,
    OP_CMPHI = 4'h6,
    OP_XOR   = 4'h7,
    OP_CLR   = 4'h8,
    OP_OR    = 4'h9,
    OP_NOT   = 4'hA,
    OP_JMP   = 4'hB,
    OP_PASS  = 4'hC,
    OP_SLT   = 4'hD,
    OP_ABS   = 4'hE,
    OP_NOP   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add unsigned multiplier, one multiplier bit
// per cycle, WIDTH iterations after start.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - load operands (a_i, b_i) and begin iterating
//   a_i, b_i    - multiplicand / multiplier
//   done_o      - high during the final iteration cycle
//   product_o   - full 2*WIDTH product, valid while done_o is high
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  // The last partial product is folded in combinationally so the caller can
  // register the finished product on the same edge as the final iteration.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= CNT_W'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready request/response handshake,
// an iterative multiply and a runtime-writable branch label table.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o        - request handshake
//   opcode_i, rs1_i, rs2_i, const_i  - operation and operands
//   lbl_we_i, lbl_waddr_i, lbl_wdata_i - label table write port
//   resp_valid_o / resp_ready_i      - response handshake
//   result_o, overflow_o, branch_taken_o - registered response fields
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CONST_W = 2,
  parameter int LABEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [3:0]         opcode_i,
  input  logic [WIDTH-1:0]   rs1_i,
  input  logic [WIDTH-1:0]   rs2_i,
  input  logic [CONST_W-1:0] const_i,
  input  logic               lbl_we_i,
  input  logic [LABEL_W-1:0] lbl_waddr_i,
  input  logic [WIDTH-1:0]   lbl_wdata_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               overflow_o,
  output logic               branch_taken_o
);

  localparam int DEPTH = 2 ** LABEL_W;

  state_e             state_q, state_d;
  opcode_e            op;
  logic               accept, is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               taken_q, taken_d;
  logic [WIDTH-1:0]   lbl_q [DEPTH];

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   addi_ext, addi_sum, lbl_rdata;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_ovf, alu_taken;

  assign op     = opcode_e'(opcode_i);
  assign is_mul = (op == OP_MUL);
  assign accept = req_valid_i & req_ready_o;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept & is_mul),
    .a_i       (rs1_i),
    .b_i       (rs2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A response is retired on resp_ready_i; a request accepted in that same
  // cycle replaces it without passing through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? MUL : RESP;
      MUL:     if (mul_done) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = accept ? (is_mul ? MUL : RESP) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready never looks at req_valid_i so upstream cannot form a comb loop.
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      RESP: begin
        resp_valid_o = 1'b1;
        req_ready_o  = resp_ready_i;
      end
      default: ;
    endcase
  end

  // Label reads see the pre-edge table contents, so a write landing on the
  // same edge as a lookup is only visible to later requests.
  always_comb begin
    add_sum    = {1'b0, rs1_i} + {1'b0, rs2_i};
    addi_ext   = {{(WIDTH-CONST_W){const_i[CONST_W-1]}}, const_i};
    addi_sum   = rs1_i + addi_ext;
    lbl_rdata  = lbl_q[rs1_i[LABEL_W-1:0]];
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_taken  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result = add_sum[WIDTH-1:0];
        alu_ovf    = add_sum[WIDTH];
      end
      OP_ADDI: begin
        alu_result = addi_sum;
        alu_ovf    = (rs1_i[WIDTH-1] == addi_ext[WIDTH-1]) &&
                     (addi_sum[WIDTH-1] != rs1_i[WIDTH-1]);
      end
      OP_SUB:   alu_result = rs1_i - rs2_i;
      OP_SHL:   alu_result = rs1_i << const_i;
      OP_BEQ0: begin
        alu_result = lbl_rdata;
        alu_taken  = (rs2_i == '0);
      end
      OP_CMPHI: alu_result = {{(WIDTH-1){1'b0}},
                              (rs1_i[WIDTH-1:WIDTH/2] == rs2_i[WIDTH-1:WIDTH/2])};
      OP_XOR:   alu_result = rs1_i ^ rs2_i;
      OP_OR:    alu_result = rs1_i | rs2_i;
      OP_NOT:   alu_result = ~rs1_i;
      OP_JMP: begin
        alu_result = lbl_rdata;
        alu_taken  = 1'b1;
      end
      OP_PASS:  alu_result = rs1_i;
      OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, (rs1_i < rs2_i)};
      OP_ABS: begin
        // The most negative value has no positive twin and negates to itself.
        alu_result = rs1_i[WIDTH-1] ? (~rs1_i + 1'b1) : rs1_i;
        alu_ovf    = (rs1_i == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: ;
    endcase
  end

  always_comb begin
    result_d   = result_q;
    overflow_d = overflow_q;
    taken_d    = taken_q;
    if (accept && !is_mul) begin
      result_d   = alu_result;
      overflow_d = alu_ovf;
      taken_d    = alu_taken;
    end else if (state_q == MUL && mul_done) begin
      result_d   = mul_product[WIDTH-1:0];
      overflow_d = |mul_product[2*WIDTH-1:WIDTH];
      taken_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      taken_q    <= taken_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        lbl_q[i] <= '0;
      end
    end else if (lbl_we_i) begin
      lbl_q[lbl_waddr_i] <= lbl_wdata_i;
    end
  end

  assign result_o       = result_q;
  assign overflow_o     = overflow_q;
  assign branch_taken_o = taken_q;

endmodule
